// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: load/status bus between the game datapath and the display driver
//   number/load/mode : value, capture strobe and display mode from the datapath
//   busy/done        : conversion in progress, one-cycle display-update pulse
interface seg7_scan_driver_if #(parameter int BIN_W = 14);
  logic [BIN_W-1:0] number;
  logic             load;
  logic [1:0]       mode;
  logic             busy;
  logic             done;
  modport master (output number, load, mode, input busy, done);
  modport slave  (input number, load, mode, output busy, done);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment driver with sequential binary-to-BCD conversion
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of seg7_scan_driver_if (number, load, mode, busy, done)
//   seg      : {g,f,e,d,c,b,a}, active-low
//   an       : digit enables, active-low one-hot, digit 0 least significant
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int SCAN_DIV   = 25000,
  parameter int BLINK_DIV  = 2500000,
  parameter int LZB        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_scan_driver_if.slave     bus,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(BIN_W);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  function automatic logic [63:0] pow10(input int n);
    pow10 = 64'd1;
    for (int i = 0; i < n; i++) pow10 = pow10 * 64'd10;
  endfunction
  localparam logic [63:0] LIM = pow10(NUM_DIGITS);
  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'h0: dec7 = 7'h40;
      4'h1: dec7 = 7'h79;
      4'h2: dec7 = 7'h24;
      4'h3: dec7 = 7'h30;
      4'h4: dec7 = 7'h19;
      4'h5: dec7 = 7'h12;
      4'h6: dec7 = 7'h02;
      4'h7: dec7 = 7'h78;
      4'h8: dec7 = 7'h00;
      4'h9: dec7 = 7'h10;
      4'hA: dec7 = 7'h08;
      4'hB: dec7 = 7'h03;
      4'hC: dec7 = 7'h46;
      4'hD: dec7 = 7'h21;
      4'hE: dec7 = 7'h06;
      default: dec7 = 7'h0E;
    endcase
  endfunction
  logic [BIN_W-1:0]      sh;
  logic [DW-1:0]         bcd, adj, disp, bcd_n, sel;
  logic [BIN_W-1:0]      sh_n;
  logic [DW+BIN_W-1:0]   dd;
  logic [CW-1:0]         cnt;
  logic                  busy, done, pend, ovf_q, dovf, phase, phase_n;
  logic [1:0]            mode_q, dmode;
  logic [SW-1:0]         pre;
  logic [BW-1:0]         bcnt;
  logic [IW-1:0]         idx, idx_n;
  logic [NUM_DIGITS-1:0] lzv, an_n;
  logic [6:0]            seg_n;
  logic [63:0]           wide;
  logic                  cap, dec_in, ovf_in, swrap, bwrap, dec_d;
  logic [3:0]            nib;
  assign bus.busy = busy;
  assign bus.done = done;
  // double-dabble step: add 3 to every nibble >= 5, then shift the BCD:binary pair left
  always_comb begin
    adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  assign dd    = {adj, sh} << 1;
  assign bcd_n = dd[DW+BIN_W-1:BIN_W];
  assign sh_n  = dd[BIN_W-1:0];
  assign cap    = bus.load && !busy;
  assign dec_in = bus.mode == 2'd0 || bus.mode == 2'd3;
  assign wide   = 64'(bus.number);
  // overflow is judged on the raw value so the conversion can keep its fixed length
  assign ovf_in = dec_in ? wide >= LIM : (wide >> DW) != 64'd0;
  assign swrap   = pre == SW'(SCAN_DIV - 1);
  assign bwrap   = bcnt == BW'(BLINK_DIV - 1);
  assign idx_n   = idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
  assign phase_n = bwrap ? ~phase : phase;
  assign sel     = disp >> {idx_n, 2'b00};
  assign nib     = sel[3:0];
  assign dec_d   = dmode == 2'd0 || dmode == 2'd3;
  assign an_n    = ~(NUM_DIGITS'(1) << idx_n);
  // lzv[i]: digit i and everything above it are zero
  always_comb begin
    lzv = '0;
    for (int i = 0; i < NUM_DIGITS; i++) lzv[i] = (disp >> (4 * i)) == '0;
  end
  // outputs are registered on the scan wrap, so use next-cycle index and blink phase
  assign seg_n = dmode == 2'd2 || (dmode == 2'd3 && phase_n) ? 7'h7F :
                 dovf ? 7'h3F :
                 LZB != 0 && dec_d && idx_n != '0 && lzv[idx_n] ? 7'h7F : dec7(nib);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh     <= '0;
      bcd    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pend   <= 1'b0;
      mode_q <= 2'd2;
      ovf_q  <= 1'b0;
      disp   <= '0;
      dmode  <= 2'd2;
      dovf   <= 1'b0;
      pre    <= '0;
      bcnt   <= '0;
      phase  <= 1'b0;
      idx    <= '0;
      seg    <= 7'h7F;
      an     <= '1;
    end else begin
      done  <= 1'b0;
      pend  <= 1'b0;
      pre   <= swrap ? '0 : pre + 1'b1;
      bcnt  <= bwrap ? '0 : bcnt + 1'b1;
      phase <= phase_n;
      if (swrap) begin
        idx <= idx_n;
        an  <= an_n;
        seg <= seg_n;
      end
      if (busy) begin
        sh  <= sh_n;
        bcd <= bcd_n;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(BIN_W - 1)) begin
          busy  <= 1'b0;
          disp  <= bcd_n;
          dmode <= mode_q;
          dovf  <= ovf_q;
          done  <= 1'b1;
        end
      end
      if (pend) begin
        disp  <= DW'(sh);
        dmode <= mode_q;
        dovf  <= ovf_q;
        done  <= 1'b1;
      end
      if (cap) begin
        sh     <= bus.number;
        bcd    <= '0;
        cnt    <= '0;
        mode_q <= bus.mode;
        ovf_q  <= ovf_in;
        busy   <= dec_in;
        pend   <= !dec_in;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed self-checking bench for seg7_scan_driver
//   (4 digits, 14-bit input, SCAN_DIV=4, BLINK_DIV=8)
module tb_seg7_scan_driver;
  logic       clk, rst;
  logic [6:0] seg;
  logic [3:0] an;
  int         n_vec, n_bad, ncyc;
  int         lat, bc, nd;
  logic [6:0] d1234 [4];
  seg7_scan_driver_if #(.BIN_W(14)) bus();
  seg7_scan_driver #(.NUM_DIGITS(4), .BIN_W(14), .SCAN_DIV(4), .BLINK_DIV(8), .LZB(1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .seg(seg), .an(an));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst)
    if (!rst) ncyc <= 0;
    else ncyc <= ncyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] exp_an(input int n);
    exp_an = n < 4 ? 4'hF : ~(4'b1 << ((n / 4) % 4));
  endfunction
  task automatic run(input logic [13:0] num, input logic [1:0] md, input logic [13:0] num2,
                     input int at2, output int l, output int b, output int d);
    @(negedge clk);
    bus.number = num;
    bus.mode = md;
    bus.load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0;
    l = -1;
    b = 0;
    d = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.busy) b++;
      if (bus.done) begin
        d++;
        if (l < 0) l = c;
      end
      if (c == at2) begin
        bus.number = num2;
        bus.load = 1'b1;
      end else bus.load = 1'b0;
    end
  endtask
  task automatic sweep(input string tag, input logic [27:0] exp);
    logic [6:0] got [4];
    logic [3:0] seen;
    seen = '0;
    for (int i = 0; i < 4; i++) got[i] = '0;
    repeat (16) @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (an == ~(4'b1 << i)) begin
          got[i] = seg;
          seen[i] = 1'b1;
        end
    end
    chk({tag, "_seen"}, seen, 4'hF);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_d%0d", tag, i), got[i], exp[7*i +: 7]);
  endtask
  initial begin
    n_vec = 0;
    n_bad = 0;
    d1234 = '{7'h19, 7'h30, 7'h24, 7'h79};
    rst = 1'b0;
    bus.number = '0;
    bus.mode = 2'd0;
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", an, 4'hF);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_an", an, exp_an(ncyc));
      chk("post_rst_seg", seg, 7'h7F);
    end
    run(14'd1234, 2'd0, 14'd0, -1, lat, bc, nd);
    chk("dec_lat", lat, 14);
    chk("dec_busy", bc, 14);
    chk("dec_done", nd, 1);
    sweep("dec1234", {7'h79, 7'h24, 7'h30, 7'h19});
    run(14'd7, 2'd0, 14'd0, -1, lat, bc, nd);
    chk("lz_lat", lat, 14);
    sweep("lz7", {7'h7F, 7'h7F, 7'h7F, 7'h78});
    run(14'd12000, 2'd0, 14'd0, -1, lat, bc, nd);
    chk("ovf_lat", lat, 14);
    sweep("ovf", {7'h3F, 7'h3F, 7'h3F, 7'h3F});
    run(14'h1ABC, 2'd1, 14'd0, -1, lat, bc, nd);
    chk("hex_lat", lat, 1);
    chk("hex_busy", bc, 0);
    chk("hex_done", nd, 1);
    sweep("hex", {7'h79, 7'h08, 7'h03, 7'h46});
    run(14'd5678, 2'd0, 14'd1111, 2, lat, bc, nd);
    chk("lwb_lat", lat, 14);
    chk("lwb_done", nd, 1);
    sweep("lwb", {7'h12, 7'h02, 7'h78, 7'h00});
    run(14'd1234, 2'd3, 14'd0, -1, lat, bc, nd);
    chk("blink_lat", lat, 14);
    repeat (8) @(negedge clk);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      chk("blink_an", an, exp_an(ncyc));
      chk("blink_seg", seg, ((ncyc / 8) % 2) == 1 ? 7'h7F : d1234[(ncyc / 4) % 4]);
    end
    @(negedge clk);
    bus.number = 14'd1234;
    bus.mode = 2'd0;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_pre", bus.busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_seg", seg, 7'h7F);
    chk("abort_an", an, 4'hF);
    @(negedge clk);
    rst = 1'b1;
    nd = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_idle", bus.busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
